// File: rtl/lieat_general_pipebuf_pkg.sv
// Shared constants and helpers for the lieat elastic pipeline buffer.
// Pointer wrap is explicit so non-power-of-2 depths work correctly.
package lieat_general_pipebuf_pkg;

  localparam int          LIEAT_XLEN     = 32;
  localparam logic [31:0] LIEAT_PC_RESET = 32'h8000_0000;

  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_PUSH = 2'b01,
    BUF_POP  = 2'b10,
    BUF_XFER = 2'b11
  } buf_op_e;

  function automatic int ptr_wrap(input int ptr, input int depth);
    if (ptr >= depth - 32'sd1) begin
      return 32'sd0;
    end else begin
      return ptr + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/lieat_general_dffln.sv
// One DW-wide storage word with load enable, async active-low reset to DEFAULT
// and a synchronous clear back to DEFAULT.
module lieat_general_dffln #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] DEFAULT = {DW{1'b0}}
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          loaden,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] word_r;

  // storage word: reset/clear to DEFAULT, otherwise load when enabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_r <= DEFAULT;
    end else if (clear) begin
      word_r <= DEFAULT;
    end else if (loaden) begin
      word_r <= din;
    end
  end

  assign qout = word_r;

endmodule

// File: rtl/lieat_general_pipebuf_chk.sv
// Occupancy invariants of the pipeline buffer: never push when full,
// never pop when empty.
module lieat_general_pipebuf_chk #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          clock,
  input logic          reset,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);

  a_push_not_full: assert property (@(posedge clock) disable iff (!reset)
    push |-> (count < CW'(DEPTH)));

  a_pop_not_empty: assert property (@(posedge clock) disable iff (!reset)
    pop |-> (count > {CW{1'b0}}));

endmodule

// File: rtl/lieat_general_pipebuf.sv
// DEPTH-entry valid/ready elastic buffer with reset default, settle cycle,
// synchronous flush and optional zero-latency bypass when empty.
module lieat_general_pipebuf
  import lieat_general_pipebuf_pkg::*;
#(
  parameter int            DW      = LIEAT_XLEN,
  parameter int            DEPTH   = 2,
  parameter logic [DW-1:0] DEFAULT = {DW{1'b0}},
  parameter bit            BYPASS  = 1'b0,
  parameter int            CW      = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          s1_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [DW-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] load_s;

  logic          empty_s;
  logic          full_s;
  logic          in_ready_s;
  logic          pass_s;
  logic          push_s;
  logic          pop_s;
  logic          out_valid_s;
  logic [DW-1:0] out_data_s;
  buf_op_e       op_s;

  // handshake qualification; in_ready never looks at out_ready
  always_comb begin
    empty_s    = (count_r == {CW{1'b0}});
    full_s     = (count_r == CW'(DEPTH));
    in_ready_s = s1_r & ~flush & ~full_s;
    // a bypassed word consumed the same cycle is never written
    pass_s     = BYPASS & empty_s & in_valid & s1_r & ~flush & out_ready;
    push_s     = in_valid & in_ready_s & ~pass_s;
    pop_s      = ~empty_s & out_ready & ~flush;
  end

  // head selection: stored word, bypassed input, or the empty default
  always_comb begin
    out_valid_s = 1'b0;
    out_data_s  = DEFAULT;
    if (!empty_s) begin
      out_valid_s = 1'b1;
      out_data_s  = entry_q[rd_ptr_r];
    end else if (BYPASS) begin
      out_valid_s = in_valid & s1_r & ~flush;
      out_data_s  = (in_valid & s1_r) ? in_data : DEFAULT;
    end else begin
      out_valid_s = 1'b0;
      out_data_s  = DEFAULT;
    end
  end

  // classify the per-cycle update
  always_comb begin
    op_s = BUF_IDLE;
    case ({pop_s, push_s})
      2'b01:   op_s = BUF_PUSH;
      2'b10:   op_s = BUF_POP;
      2'b11:   op_s = BUF_XFER;
      default: op_s = BUF_IDLE;
    endcase
  end

  // control state: settle flag, pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_r     <= 1'b0;
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else begin
      s1_r <= 1'b1;
      if (flush) begin
        count_r  <= {CW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        case (op_s)
          BUF_PUSH: begin
            wr_ptr_r <= PW'(ptr_wrap(32'(wr_ptr_r), DEPTH));
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
          end
          BUF_POP: begin
            rd_ptr_r <= PW'(ptr_wrap(32'(rd_ptr_r), DEPTH));
            count_r  <= count_r - {{(CW-1){1'b0}}, 1'b1};
          end
          BUF_XFER: begin
            wr_ptr_r <= PW'(ptr_wrap(32'(wr_ptr_r), DEPTH));
            rd_ptr_r <= PW'(ptr_wrap(32'(rd_ptr_r), DEPTH));
          end
          default: begin
            count_r <= count_r;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign load_s[i] = push_s & (wr_ptr_r == PW'(i));

    lieat_general_dffln #(
      .DW      (DW),
      .DEFAULT (DEFAULT)
    ) u_entry (
      .clock  (clock),
      .reset  (reset),
      .clear  (flush),
      .loaden (load_s[i]),
      .din    (in_data),
      .qout   (entry_q[i])
    );
  end

  lieat_general_pipebuf_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = out_data_s;
  assign count     = count_r;

endmodule

// File: tb/tb_lieat_general_pipebuf.sv
// Self-checking bench: three buffer configurations, a data scoreboard per
// instance, a vector table for fill/drain/flush and hand-written corner cases.
module tb_lieat_general_pipebuf;
  import lieat_general_pipebuf_pkg::*;

  localparam logic [31:0] DEF_A = LIEAT_PC_RESET;
  localparam logic [31:0] DEF_B = 32'hDEFA_0017;
  localparam logic [31:0] DEF_C = 32'h0000_0000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // A: DEPTH=2 registered, B: DEPTH=3 registered, C: DEPTH=2 bypass
  logic a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic c_reset, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] a_in_data, a_out_data, b_in_data, b_out_data, c_in_data, c_out_data;
  logic [1:0]  a_count, b_count, c_count;

  lieat_general_pipebuf #(.DW(32), .DEPTH(2), .DEFAULT(DEF_A), .BYPASS(1'b0)) u_a (
    .clock(clock), .reset(a_reset), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count));

  lieat_general_pipebuf #(.DW(32), .DEPTH(3), .DEFAULT(DEF_B), .BYPASS(1'b0)) u_b (
    .clock(clock), .reset(b_reset), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count));

  lieat_general_pipebuf #(.DW(32), .DEPTH(2), .DEFAULT(DEF_C), .BYPASS(1'b1)) u_c (
    .clock(clock), .reset(c_reset), .flush(c_flush), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count));

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [31:0] od;
    logic [1:0]  cnt;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] sbq [3][$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: accepted words are queued, delivered words must match the head
  task automatic mon(input int k, input logic rst, input logic fl, input logic iv,
                     input logic ir, input logic [31:0] id, input logic ov,
                     input logic ordy, input logic [31:0] od);
    logic [31:0] exp;
    if (!rst || fl) begin
      sbq[k].delete();
    end else begin
      if (iv && ir) sbq[k].push_back(id);
      if (ov && ordy) begin
        if (sbq[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb%0d_extra: got %h expected no word", k, od);
        end else begin
          exp = sbq[k].pop_front();
          chk($sformatf("sb%0d_data", k), od, exp);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    mon(0, a_reset, a_flush, a_in_valid, a_in_ready, a_in_data, a_out_valid, a_out_ready, a_out_data);
    mon(1, b_reset, b_flush, b_in_valid, b_in_ready, b_in_data, b_out_valid, b_out_ready, b_out_data);
    mon(2, c_reset, c_flush, c_in_valid, c_in_ready, c_in_data, c_out_valid, c_out_ready, c_out_data);
    @(posedge clock);
    #1;
  endtask

  initial begin
    //            fl    iv    d          ordy  ov    ir    od     cnt-after
    tbl[0]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, DEF_B,  2'd1};
    tbl[1]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2};
    tbl[2]  = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h11, 2'd3};
    tbl[3]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 32'h11, 2'd2};
    tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h33, 2'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, DEF_B,  2'd0};
    tbl[7]  = '{1'b0, 1'b1, 32'h01, 1'b0, 1'b0, 1'b1, DEF_B,  2'd1};
    tbl[8]  = '{1'b0, 1'b1, 32'h02, 1'b0, 1'b1, 1'b1, 32'h01, 2'd2};
    tbl[9]  = '{1'b1, 1'b1, 32'hAA, 1'b1, 1'b1, 1'b0, 32'h01, 2'd0};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, DEF_B,  2'd0};

    a_reset = 1'b0; a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h1234_5678; a_out_ready = 1'b0;
    b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 32'h0;         b_out_ready = 1'b0;
    c_reset = 1'b0; c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 32'h0;         c_out_ready = 1'b0;

    // reset state, in_valid held high on A
    #1;
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data", a_out_data, DEF_A);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_out_data", b_out_data, DEF_B);
    @(posedge clock);
    #1;

    // release between edges; edge 1 only settles, edge 2 may push
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    #1;
    chk("settle_e1_in_ready", 32'(a_in_ready), 32'd0);
    chk("settle_e1_out_data", a_out_data, DEF_A);
    tick();
    chk("settle_e2_in_ready", 32'(a_in_ready), 32'd1);
    chk("settle_e2_out_valid", 32'(a_out_valid), 32'd0);
    tick();
    chk("settle_out_valid", 32'(a_out_valid), 32'd1);
    chk("settle_out_data", a_out_data, 32'h1234_5678);
    chk("settle_count", 32'(a_count), 32'd1);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("settle_drain_count", 32'(a_count), 32'd0);
    a_out_ready = 1'b0;

    // async reset with two words stored
    a_in_valid = 1'b1; a_in_data = 32'hA1;
    tick();
    a_in_data = 32'hA2;
    tick();
    a_in_valid = 1'b0;
    chk("areset_pre_count", 32'(a_count), 32'd2);
    #2;
    a_reset = 1'b0;
    #1;
    chk("areset_out_valid", 32'(a_out_valid), 32'd0);
    chk("areset_in_ready", 32'(a_in_ready), 32'd0);
    chk("areset_count", 32'(a_count), 32'd0);
    chk("areset_out_data", a_out_data, DEF_A);
    tick();
    a_reset = 1'b1;
    #1;
    chk("areset_resettle_lo", 32'(a_in_ready), 32'd0);
    tick();
    chk("areset_resettle_hi", 32'(a_in_ready), 32'd1);

    // fill / full-with-pop / drain / flush on DEPTH=3
    for (int i = 0; i < 11; i++) begin
      b_flush = tbl[i].fl; b_in_valid = tbl[i].iv; b_in_data = tbl[i].d; b_out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 32'(b_out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_in_ready", i), 32'(b_in_ready), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_out_data", i), b_out_data, tbl[i].od);
      tick();
      chk($sformatf("tbl%0d_count", i), 32'(b_count), 32'(tbl[i].cnt));
    end
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;

    // streaming through pointer wrap with one word resident
    b_in_valid = 1'b1; b_in_data = 32'd0;
    tick();
    chk("stream_prime_count", 32'(b_count), 32'd1);
    for (int i = 1; i < 10; i++) begin
      b_in_data = 32'(i);
      b_out_ready = 1'b1;
      tick();
      chk($sformatf("stream%0d_count", i), 32'(b_count), 32'd1);
    end
    b_in_valid = 1'b0;
    tick();
    chk("stream_end_count", 32'(b_count), 32'd0);
    b_out_ready = 1'b0;

    // bypass: pass-through when consumed, stored when stalled
    c_in_valid = 1'b1; c_in_data = 32'h55; c_out_ready = 1'b1;
    #1;
    chk("byp_pass_out_valid", 32'(c_out_valid), 32'd1);
    chk("byp_pass_out_data", c_out_data, 32'h55);
    tick();
    chk("byp_pass_count", 32'(c_count), 32'd0);
    c_out_ready = 1'b0;
    #1;
    chk("byp_stall_out_data", c_out_data, 32'h55);
    tick();
    chk("byp_stall_count", 32'(c_count), 32'd1);
    c_in_valid = 1'b0;
    #1;
    chk("byp_held_out_valid", 32'(c_out_valid), 32'd1);
    chk("byp_held_out_data", c_out_data, 32'h55);
    c_out_ready = 1'b1;
    tick();
    chk("byp_drain_count", 32'(c_count), 32'd0);
    c_out_ready = 1'b0;
    #1;
    chk("byp_empty_out_valid", 32'(c_out_valid), 32'd0);
    chk("byp_empty_out_data", c_out_data, DEF_C);
    c_flush = 1'b1; c_in_valid = 1'b1; c_in_data = 32'h77; c_out_ready = 1'b1;
    #1;
    chk("byp_flush_out_valid", 32'(c_out_valid), 32'd0);
    tick();
    chk("byp_flush_count", 32'(c_count), 32'd0);
    c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    tick();

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sb%0d_leftover", k), 32'(sbq[k].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lieat_general_pipebuf.md
Name: lieat_general_pipebuf

Overview:
- Parametrised elastic pipeline register. It generalises the single-word reset-default DFF into a DEPTH-entry valid/ready buffer.
- Features: configurable reset/empty default value, post-reset settle cycle, synchronous flush, optional empty-bypass mode.
- Placed between pipe stages (IF→ID, EX→MEM, LSU response) wherever backpressure or stall decoupling is needed.

Parameters:
- DW, 32, data width in bits (≥1).
- DEPTH, 2, number of storage entries (≥1; non-power-of-2 allowed).
- DEFAULT, {DW{1'b0}}, value driven on out_data while empty and loaded into all entries at reset/flush.
- BYPASS, 0, 1 = empty buffer forwards in_data combinationally to the output (zero latency); 0 = registered, minimum latency 1 cycle.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all contents; highest priority.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  buffer accepts a word this cycle.
- in_data  input  DW  upstream word.
- out_valid  output  1  head word valid.
- out_ready  input  1  downstream accepts head this cycle.
- out_data  output  DW  head word, or DEFAULT when empty.
- count  output  CW  current occupancy 0..DEPTH.

Behaviour:
- Reset (reset=0, async): all entries=DEFAULT, rd_ptr=wr_ptr=0, count=0, settle flag s1=0.
  - Outputs during reset: in_ready=0, out_valid=0, out_data=DEFAULT.
- Settle: s1 becomes 1 on the first clock edge after reset deasserts. in_ready is held 0 while s1=0, so the first push can happen no earlier than the second edge after release.
- Handshake:
  - in_ready = s1 & ~flush & (count<DEPTH).
  - push = in_valid & in_ready; pop = out_valid & out_ready & ~flush.
  - in_ready has no combinational dependence on out_ready. When full, a same-cycle pop does not allow a push.
  - in_valid/in_data may change freely while in_ready=0. Out side follows standard valid/ready; out_data is held stable while out_valid & ~out_ready.
- BYPASS=0:
  - out_valid = (count!=0); out_data = entry[rd_ptr] when count!=0, else DEFAULT.
  - Latency from push to out_valid is 1 cycle.
- BYPASS=1, count==0:
  - out_valid = in_valid & s1 & ~flush; out_data = in_valid ? in_data : DEFAULT.
  - If out_ready in the same cycle, the word passes through and is not stored: count stays 0, pointers unchanged.
  - Otherwise the word is written (normal push).
- Update on clock edge, in priority order:
  - flush: count←0, pointers←0, entries←DEFAULT. Any in_valid word this cycle is discarded; a concurrent pop is ignored.
  - push only: entry[wr_ptr]←in_data, wr_ptr advances, count+1.
  - pop only: rd_ptr advances, count−1, vacated entry keeps its old data (not cleared).
  - push & pop, count in 1..DEPTH−1: both pointers advance, count unchanged. FIFO order is preserved.
- Pointer wrap: ptr==DEPTH−1 advances to 0. Do not use modulo-2^n arithmetic, since DEPTH may be non-power-of-2.
- DEPTH=1: behaves as a half-rate register slice. in_ready=0 while full, even if out_ready=1.
- Reset asserted mid-transfer: contents are lost immediately, outputs go to their reset values asynchronously, and the settle cycle repeats after release.
- No overflow/underflow is possible by construction. Assertions: push⇒count<DEPTH, pop⇒count>0.

Decomposition:
- Shared include lieat_defines.vh:
  - LIEAT_XLEN=32.
  - Pipe reset vector constant LIEAT_PC_RESET=32'h80000000, used as DEFAULT for PC-carrying instances.
- Sub-module lieat_general_dffln: DW-wide storage word with loaden, async active-low reset, DEFAULT parameter.
  - Instantiated DEPTH times for entries.
  - Control (pointers, count, s1) stays in lieat_general_pipebuf.

Test Plan:
- Reset/settle: DW=32, DEPTH=2, DEFAULT=32'h80000000, in_valid=1 throughout reset release → edge 1: in_ready=0, out_data=32'h80000000; edge 2: in_ready=1; after edge 2: out_valid=1, out_data=in_data.
- Fill/drain: DEPTH=3, push 0x11, 0x22, 0x33 with out_ready=0 → count=3, in_ready=0; then out_ready=1 for 3 cycles → out_data sequence 0x11, 0x22, 0x33, count returns to 0, out_data=DEFAULT.
- Wrap + streaming: DEPTH=3, continuous push/pop of 0..9 with count held at 1 → output order 0..9, count constant 1, pointers wrap at 2→0.
- Flush: count=2, flush=1 with in_valid=1 (0xAA) and out_ready=1 → next cycle count=0, out_valid=0, out_data=DEFAULT, 0xAA never appears.
- Bypass: BYPASS=1, empty, in_valid=1, in_data=0x55, out_ready=1 → same-cycle out_valid=1, out_data=0x55, count stays 0; repeat with out_ready=0 → count=1, next cycle out_data=0x55.
- Async reset mid-stream: assert reset between clock edges with count=2 → out_valid=0, in_ready=0, count=0 before the next edge.
